// File: rtl/mips_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO register pair.
// Command handshake: start is taken only while busy is low (IDLE), together
// with op and operands; busy then stays high until the result cycle ends.
// done (mirrored on hi_we/lo_we) is high for exactly one cycle, in which
// hi_out/lo_out carry the new result. A start seen while busy is dropped.
// The multiply is shift-add and the divide is restoring, each handling one bit per cycle.
module mips_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    // FIX applies the sign correction and registers HI/LO; DONE presents them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d; // product high half / remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier-then-product low / quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Signed ops work on magnitudes; the signs are reapplied in FIX.
    assign a_abs = (op[0] & operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign b_abs = (op[0] & operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // One shift-add step: conditional add into the upper half keeps its carry.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

    // One restoring step: shift {rem,quot} left and try subtracting the divisor.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_trial = WIDTH'(div_shift - {1'b0, opnd_q});

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = (is_signed_q & (sa_q ^ sb_q)) ? -prod : prod;
    assign quot_fix = (is_signed_q & (sa_q ^ sb_q)) ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = (is_signed_q & sa_q) ? -acc_hi_q : acc_hi_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        b_zero_d    = b_zero_q;
        a_raw_d     = a_raw_q;
        opnd_d      = opnd_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d    = op[1];
                    is_signed_d = op[0];
                    sa_d        = op[0] & operand_a[WIDTH-1];
                    sb_d        = op[0] & operand_b[WIDTH-1];
                    b_zero_d    = (operand_b == '0);
                    a_raw_d     = operand_a;
                    opnd_d      = op[1] ? b_abs : a_abs;
                    acc_hi_d    = '0;
                    acc_lo_d    = op[1] ? a_abs : b_abs;
                    cnt_d       = CNT_INIT;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                if (!is_div_q) begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end else if (div_ge) begin
                    acc_hi_d = div_trial;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_zero_q) begin
                    // Divide by zero returns the dividend as given, whatever the sign mode.
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            b_zero_q    <= 1'b0;
            a_raw_q     <= '0;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            b_zero_q    <= b_zero_d;
            a_raw_q     <= a_raw_d;
            opnd_q      <= opnd_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hi_we     = done;
    assign lo_we     = done;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed and random checks of the multiply/divide sequencer against a
// plain-arithmetic reference model (64-bit products, native / and %).
module tb_mips_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res = '0;

    mips_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: {hi, lo} from the architectural definition of each op.
    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint   sp;
        logic [W-1:0] q;
        logic [W-1:0] r;
        case (o)
            2'd0: return {32'b0, a} * {32'b0, b};
            2'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd2) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Driver: called at a falling edge; start is sampled at the next rising edge.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start     = 1'b0;
        op        = 2'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Waits for done, checking latency, busy span, strobes and the result.
    // restart_at >= 0 pulses start with fresh operands at that cycle.
    task automatic finish_op(input int restart_at);
        int k = 0;
        int busy_cycles = 0;
        logic [2*W-1:0] expv;
        check("hold_prev", {hi_out, lo_out}, last_res);
        while (done !== 1'b1 && k < W + 10) begin
            if (busy === 1'b1) busy_cycles++;
            if (k == restart_at) begin
                start     = 1'b1;
                op        = 2'($urandom_range(0, 3));
                operand_a = $urandom;
                operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("done_latency", k, W + 1);
        if (done === 1'b1) begin
            if (busy === 1'b1) busy_cycles++;
            check("write_strobes", {hi_we, lo_we}, 2'b11);
            check("result", {hi_out, lo_out}, expv);
            last_res = expv;
        end
        @(negedge clk);
        check("after_done", {done, hi_we, lo_we, busy}, 4'b0000);
        check("busy_cycles", busy_cycles, W + 2);
        check("result_hold", {hi_out, lo_out}, last_res);
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(o, a, b);
        finish_op(-1);
    endtask

    // Stimulus sequence
    initial begin
        int strays;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {busy, done, hi_we, lo_we}, 4'b0000);
        check("reset_hilo", {hi_out, lo_out}, 64'h0);
        check("reset_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // Directed cases
        run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd1, 32'hFFFF_FFFD, 32'd7);
        run(2'd3, 32'hFFFF_FFF9, 32'd2);
        run(2'd2, 32'd100, 32'd7);
        run(2'd2, 32'h0000_1234, 32'd0);
        run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd3, 32'hFFFF_FFFB, 32'd0);
        run(2'd1, 32'h8000_0000, 32'h8000_0000);
        run(2'd3, 32'd7, 32'hFFFF_FFFE);

        // Start pulsed mid-CALC with new operands must be ignored
        start_op(2'd1, 32'h0001_2345, 32'hFFFF_FF00);
        finish_op(10);
        strays = 0;
        for (int i = 0; i < W + 6; i++) begin
            if (done === 1'b1 || hi_we === 1'b1) strays++;
            @(negedge clk);
        end
        check("no_second_done", strays, 0);

        // Reset during CALC aborts without a write strobe
        start_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_hilo", {hi_out, lo_out}, 64'h0);
        void'(exp_q.pop_front());
        last_res = '0;
        strays = 0;
        for (int i = 0; i < W + 6; i++) begin
            if (done === 1'b1 || hi_we === 1'b1 || lo_we === 1'b1) strays++;
            @(negedge clk);
        end
        check("abort_no_done", strays, 0);
        run(2'd2, 32'hFFFF_FFFF, 32'd10);

        // Random operations, biased towards divisor corner values
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(2, 50));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            run(2'($urandom_range(0, 3)), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
